// File: rtl/wah_sweep_ctrl_pkg.sv
// wah_pkg: shared types and constants for the wah sweep controller.
//   sweep_state_t   - controller FSM states
//   FRAC_BITS       - fractional bits of the sweep accumulator and rate
//   ENV_DECAY_SHIFT - envelope decay per sample is env >> ENV_DECAY_SHIFT
package wah_pkg;

    localparam int unsigned FRAC_BITS       = 8;
    localparam int unsigned ENV_DECAY_SHIFT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        HOLD = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/wah_sweep_ctrl_env.sv
// wah_env: peak-hold / exponential-decay envelope follower.
// Only built when WAH_ENV_FOLLOW_EN is defined.
// Ports:
//   clk    - system clock
//   rst    - synchronous, active-high reset (env -> 0)
//   vld_i  - one-cycle sample strobe; env updates only on this strobe
//   data_i - signed audio sample
//   env    - current envelope, |data_i| scaled to COEF_WIDTH bits
`ifdef WAH_ENV_FOLLOW_EN
module wah_env
    import wah_pkg::*;
#(
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vld_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [COEF_WIDTH-1:0] env
);

    logic [DATA_WIDTH-1:0] abs_val;
    logic [DATA_WIDTH-1:0] mag_full;
    logic [COEF_WIDTH-1:0] mag;
    logic [COEF_WIDTH-1:0] decayed;
    logic [COEF_WIDTH-1:0] env_q;
    logic [COEF_WIDTH-1:0] env_d;

    // Most negative input negates to itself, which read unsigned is the correct magnitude.
    assign abs_val  = data_i[DATA_WIDTH-1] ? (~data_i + DATA_WIDTH'(1)) : data_i;
    assign mag_full = abs_val >> (DATA_WIDTH - COEF_WIDTH);
    assign mag      = mag_full[COEF_WIDTH-1:0];
    assign decayed  = env_q - (env_q >> ENV_DECAY_SHIFT);

    always_comb begin
        env_d = env_q;
        if (vld_i) begin
            env_d = (mag > decayed) ? mag : decayed;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            env_q <= '0;
        end else begin
            env_q <= env_d;
        end
    end

    assign env = env_q;

endmodule
`endif

// File: rtl/wah_sweep_ctrl.sv
// wah_sweep_ctrl: sample-aligned triangle LFO producing the eff_wah centre-frequency
// coefficient, bouncing between inclusive bounds lo and hi, pausable via en.
// Optional feature macro: WAH_ENV_FOLLOW_EN (adds data_i/mode and an envelope-follower mode).
// Ports:
//   clk      - system clock
//   rst      - synchronous, active-high reset
//   en       - sweep enable; low freezes the sweep
//   vld_i    - one-cycle sample strobe; sweep advances only on it
//   rate     - unsigned step per sample, FRAC_BITS fractional bits
//   lo, hi   - inclusive sweep bounds
//   data_i   - signed audio sample (WAH_ENV_FOLLOW_EN only)
//   mode     - 0 triangle, 1 envelope (WAH_ENV_FOLLOW_EN only)
//   coef     - current coefficient
//   coef_vld - one-cycle pulse when coef is updated
//   dir      - 1 rising, 0 falling
module wah_sweep_ctrl
    import wah_pkg::*;
#(
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned RATE_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  vld_i,
    input  logic [RATE_WIDTH-1:0] rate,
    input  logic [COEF_WIDTH-1:0] lo,
    input  logic [COEF_WIDTH-1:0] hi,
`ifdef WAH_ENV_FOLLOW_EN
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  mode,
`endif
    output logic [COEF_WIDTH-1:0] coef,
    output logic                  coef_vld,
    output logic                  dir
);

    localparam int unsigned ACC_W = COEF_WIDTH + FRAC_BITS;
    // Two guard bits: one for overflow above the top, one sign bit for underflow below zero.
    localparam int unsigned EXT_W = ACC_W + 2;

    if (DATA_WIDTH < COEF_WIDTH) begin : g_bad_data_width
        $error("DATA_WIDTH must be at least COEF_WIDTH");
    end
    if (RATE_WIDTH > ACC_W) begin : g_bad_rate_width
        $error("RATE_WIDTH must not exceed COEF_WIDTH + FRAC_BITS");
    end

    sweep_state_t     state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             dir_q, dir_d;
    logic             vld_q, vld_d;

    logic [ACC_W-1:0]        lo_acc, hi_acc;
    logic signed [EXT_W-1:0] acc_ext, rate_ext, lo_ext, hi_ext;
    logic signed [EXT_W-1:0] nxt_up, nxt_dn;

    assign lo_acc   = {lo, {FRAC_BITS{1'b0}}};
    assign hi_acc   = {hi, {FRAC_BITS{1'b0}}};
    assign acc_ext  = $signed({2'b00, acc_q});
    assign rate_ext = $signed({{(EXT_W - RATE_WIDTH){1'b0}}, rate});
    assign lo_ext   = $signed({2'b00, lo_acc});
    assign hi_ext   = $signed({2'b00, hi_acc});
    assign nxt_up   = acc_ext + rate_ext;
    assign nxt_dn   = acc_ext - rate_ext;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        dir_d   = dir_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    acc_d   = lo_acc;
                    dir_d   = 1'b1;
                    vld_d   = 1'b1;
                    state_d = RISE;
                end
            end
            RISE, FALL: begin
                // en has priority over a coincident strobe.
                if (!en) begin
                    state_d = HOLD;
                end else if (vld_i) begin
                    vld_d = 1'b1;
                    if (lo >= hi) begin
                        // Degenerate range: pin to lo, keep state and direction.
                        acc_d = lo_acc;
                    end else if (state_q == RISE) begin
                        if (nxt_up >= hi_ext) begin
                            acc_d   = hi_acc;
                            dir_d   = 1'b0;
                            state_d = FALL;
                        end else begin
                            acc_d = nxt_up[ACC_W-1:0];
                        end
                    end else begin
                        if (nxt_dn <= lo_ext) begin
                            acc_d   = lo_acc;
                            dir_d   = 1'b1;
                            state_d = RISE;
                        end else begin
                            acc_d = nxt_dn[ACC_W-1:0];
                        end
                    end
                end
            end
            HOLD: begin
                if (en) begin
                    state_d = dir_q ? RISE : FALL;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef WAH_ENV_FOLLOW_EN
        // Envelope mode publishes a new coefficient on every sample.
        if (mode) begin
            vld_d = vld_i;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            dir_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dir_q   <= dir_d;
            vld_q   <= vld_d;
        end
    end

    assign coef_vld = vld_q;

`ifdef WAH_ENV_FOLLOW_EN
    logic [COEF_WIDTH-1:0] env;
    logic [COEF_WIDTH:0]   env_sum;

    wah_env #(
        .COEF_WIDTH(COEF_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_env (
        .clk   (clk),
        .rst   (rst),
        .vld_i (vld_i),
        .data_i(data_i),
        .env   (env)
    );

    assign env_sum = {1'b0, lo} + {1'b0, env};

    always_comb begin
        coef = acc_q[ACC_W-1:FRAC_BITS];
        dir  = dir_q;
        if (mode) begin
            coef = (env_sum > {1'b0, hi}) ? hi : env_sum[COEF_WIDTH-1:0];
            dir  = 1'b1;
        end
    end
`else
    assign coef = acc_q[ACC_W-1:FRAC_BITS];
    assign dir  = dir_q;
`endif

endmodule
